// File: rtl/bp_cac_flit_assembler.sv
// Reassembles coherence NoC flits from the tile-side link into one wide packet.
// Optional macro BP_CAC_FLIT_ASSEMBLER_LEN_CHECK_EN drops oversize packets and flags len_err_o.
module bp_cac_flit_assembler #(
    parameter int unsigned flit_width_p        = 32,
    parameter int unsigned cord_width_p        = 8,
    parameter int unsigned len_width_p         = 4,
    parameter int unsigned max_payload_width_p = 84,
    localparam int unsigned packet_width_lp    = cord_width_p + len_width_p + max_payload_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [flit_width_p-1:0]     link_data_i,
    input  logic                        link_v_i,
    output logic                        link_ready_o,
    output logic [packet_width_lp-1:0]  packet_o,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic                        len_err_o
);

    localparam int unsigned max_flits_lp = (packet_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int unsigned max_len_lp   = max_flits_lp - 1;
    localparam int unsigned idx_width_lp = (max_flits_lp > 1) ? $clog2(max_flits_lp) : 1;
    localparam int unsigned slot_bits_lp = max_flits_lp * flit_width_p;

    typedef enum logic [1:0] {
        e_header = 2'd0,
        e_body   = 2'd1,
        e_full   = 2'd2
    } state_e;

    state_e                                 r_state, w_state_n;
    logic [len_width_p-1:0]                 r_cnt, w_cnt_n;
    logic [idx_width_lp-1:0]                r_idx, w_idx_n;
    logic                                   r_drop, w_drop_n;
    logic                                   r_len_err, w_len_err_n;
    logic                                   r_ready;
    logic                                   r_v;
    logic                                   w_hs;
    logic                                   w_wr_en;
    logic                                   w_clear;
    logic [len_width_p-1:0]                 w_len;
    logic [max_flits_lp-1:0][flit_width_p-1:0] r_slots;
    logic [slot_bits_lp-1:0]                w_slots_flat;

    assign w_hs  = link_v_i & r_ready;
    assign w_len = link_data_i[cord_width_p +: len_width_p];

    // State and control registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= e_header;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_drop    <= 1'b0;
            r_len_err <= 1'b0;
            r_ready   <= 1'b0;
            r_v       <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_idx     <= w_idx_n;
            r_drop    <= w_drop_n;
            r_len_err <= w_len_err_n;
            r_ready   <= (w_state_n != e_full);
            r_v       <= (w_state_n == e_full);
        end
    end

    // Next-state, counter and slot-write control
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_idx_n     = r_idx;
        w_drop_n    = r_drop;
        w_len_err_n = r_len_err;
        w_wr_en     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            e_header: begin
                if (w_hs) begin
                    w_wr_en = 1'b1;
                    w_idx_n = idx_width_lp'(1);
                    if (w_len == '0) begin
                        w_state_n = e_full;
                    end else begin
                        w_state_n = e_body;
`ifdef BP_CAC_FLIT_ASSEMBLER_LEN_CHECK_EN
                        w_cnt_n = w_len;
                        if (w_len > len_width_p'(max_len_lp)) begin
                            w_drop_n    = 1'b1;
                            w_len_err_n = 1'b1;
                        end
`else
                        w_cnt_n = (w_len > len_width_p'(max_len_lp)) ? len_width_p'(max_len_lp) : w_len;
`endif
                    end
                end
            end
            e_body: begin
                if (w_hs) begin
                    w_wr_en = !r_drop;
                    w_idx_n = r_idx + idx_width_lp'(1);
                    w_cnt_n = r_cnt - len_width_p'(1);
                    if (r_cnt == len_width_p'(1)) begin
                        if (r_drop) begin
                            w_state_n = e_header;
                            w_drop_n  = 1'b0;
                            w_clear   = 1'b1;
                        end else begin
                            w_state_n = e_full;
                        end
                    end
                end
            end
            e_full: begin
                if (yumi_i) begin
                    w_state_n = e_header;
                    w_clear   = 1'b1;
                end
            end
            default: begin
                w_state_n = e_header;
                w_clear   = 1'b1;
            end
        endcase
        if (w_clear) begin
            w_idx_n = '0;
            w_cnt_n = '0;
        end
    end

    // Flit slot storage; cleared when a packet is consumed or dropped
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_slots <= '0;
        end else if (w_clear) begin
            r_slots <= '0;
        end else if (w_wr_en) begin
            r_slots[r_idx] <= link_data_i;
        end
    end

    assign w_slots_flat = r_slots;
    assign packet_o     = w_slots_flat[packet_width_lp-1:0];
    assign v_o          = r_v;
    assign link_ready_o = r_ready;
`ifdef BP_CAC_FLIT_ASSEMBLER_LEN_CHECK_EN
    assign len_err_o    = r_len_err;
`else
    assign len_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cac_flit_assembler.sv
// Directed self-checking bench for bp_cac_flit_assembler (default 32-bit flits, 96-bit packets).
module tb_bp_cac_flit_assembler;

    logic        clk_i;
    logic        reset_n_i;
    logic [31:0] link_data_i;
    logic        link_v_i;
    logic        link_ready_o;
    logic [95:0] packet_o;
    logic        v_o;
    logic        yumi_i;
    logic        len_err_o;

    int n_cmp;
    int n_mis;

    bp_cac_flit_assembler dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .link_data_i  (link_data_i),
        .link_v_i     (link_v_i),
        .link_ready_o (link_ready_o),
        .packet_o     (packet_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i),
        .len_err_o    (len_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one flit and hold it until the handshake edge; bounded wait.
    task automatic send_flit(input logic [31:0] d);
        logic rdy;
        int   budget;
        link_data_i = d;
        link_v_i    = 1'b1;
        budget      = 50;
        do begin
            rdy = link_ready_o;
            tick();
            budget--;
        end while (!rdy && budget > 0);
        link_v_i = 1'b0;
        if (!rdy) begin
            n_cmp++;
            n_mis++;
            $display("FAIL send_flit_timeout: ready never seen for flit %h", d);
        end
    endtask

    task automatic pop();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        tick();
        tick();
        n_cmp++; if (v_o !== 1'b0) begin n_mis++; $display("FAIL reset_v: got %b want 0", v_o); end
        n_cmp++; if (link_ready_o !== 1'b0) begin n_mis++; $display("FAIL reset_ready: got %b want 0", link_ready_o); end
        n_cmp++; if (packet_o !== 96'h0) begin n_mis++; $display("FAIL reset_packet: got %h want 0", packet_o); end
        n_cmp++; if (len_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_len_err: got %b want 0", len_err_o); end
        reset_n_i = 1'b1;
        tick();
        n_cmp++; if (link_ready_o !== 1'b1) begin n_mis++; $display("FAIL post_reset_ready: got %b want 1", link_ready_o); end
    endtask

    task automatic test_three_flit();
        send_flit(32'h123452A5);
        send_flit(32'hDEADBEEF);
        n_cmp++; if (v_o !== 1'b0) begin n_mis++; $display("FAIL three_v_early: got %b want 0", v_o); end
        send_flit(32'hCAFEF00D);
        n_cmp++; if (v_o !== 1'b1) begin n_mis++; $display("FAIL three_v: got %b want 1", v_o); end
        n_cmp++; if (packet_o !== 96'hCAFEF00D_DEADBEEF_123452A5) begin n_mis++; $display("FAIL three_packet: got %h want %h", packet_o, 96'hCAFEF00D_DEADBEEF_123452A5); end
        n_cmp++; if (link_ready_o !== 1'b0) begin n_mis++; $display("FAIL three_ready: got %b want 0", link_ready_o); end
    endtask

    // Hold with link_v_i asserted: nothing accepted until the pop, then next header the cycle after.
    task automatic test_hold();
        link_data_i = 32'h7777703C;
        link_v_i    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (v_o !== 1'b1 || link_ready_o !== 1'b0) begin n_mis++; $display("FAIL hold_ctrl[%0d]: v=%b rdy=%b want v=1 rdy=0", i, v_o, link_ready_o); end
            n_cmp++; if (packet_o !== 96'hCAFEF00D_DEADBEEF_123452A5) begin n_mis++; $display("FAIL hold_packet[%0d]: got %h", i, packet_o); end
        end
        pop();
        n_cmp++; if (v_o !== 1'b0 || link_ready_o !== 1'b1) begin n_mis++; $display("FAIL pop_ctrl: v=%b rdy=%b want v=0 rdy=1", v_o, link_ready_o); end
        n_cmp++; if (packet_o !== 96'h0) begin n_mis++; $display("FAIL pop_clear: got %h want 0", packet_o); end
        tick();
        link_v_i = 1'b0;
        n_cmp++; if (v_o !== 1'b1) begin n_mis++; $display("FAIL hold_next_v: got %b want 1", v_o); end
        n_cmp++; if (packet_o !== {64'h0, 32'h7777703C}) begin n_mis++; $display("FAIL hold_next_packet: got %h", packet_o); end
        pop();
    endtask

    task automatic test_single();
        send_flit(32'h0F0F003C);
        n_cmp++; if (v_o !== 1'b1) begin n_mis++; $display("FAIL single_v: got %b want 1", v_o); end
        n_cmp++; if (packet_o[95:32] !== 64'h0) begin n_mis++; $display("FAIL single_upper: got %h want 0", packet_o[95:32]); end
        n_cmp++; if (packet_o[31:0] !== 32'h0F0F003C) begin n_mis++; $display("FAIL single_lower: got %h want 0f0f003c", packet_o[31:0]); end
        pop();
    endtask

    task automatic test_gaps();
        send_flit(32'hAAAAA211);
        tick(); tick();
        send_flit(32'h01234567);
        tick(); tick();
        n_cmp++; if (v_o !== 1'b0 || link_ready_o !== 1'b1) begin n_mis++; $display("FAIL gap_mid: v=%b rdy=%b want v=0 rdy=1", v_o, link_ready_o); end
        send_flit(32'h89ABCDEF);
        n_cmp++; if (v_o !== 1'b1) begin n_mis++; $display("FAIL gap_v: got %b want 1", v_o); end
        n_cmp++; if (packet_o !== 96'h89ABCDEF_01234567_AAAAA211) begin n_mis++; $display("FAIL gap_packet: got %h", packet_o); end
        pop();
    endtask

    task automatic test_yumi_ignored();
        yumi_i = 1'b1;
        tick(); tick();
        yumi_i = 1'b0;
        n_cmp++; if (v_o !== 1'b0 || link_ready_o !== 1'b1) begin n_mis++; $display("FAIL yumi_idle: v=%b rdy=%b want v=0 rdy=1", v_o, link_ready_o); end
        send_flit(32'h11111144);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        send_flit(32'h22222222);
        n_cmp++; if (v_o !== 1'b1) begin n_mis++; $display("FAIL yumi_body_v: got %b want 1", v_o); end
        n_cmp++; if (packet_o !== {32'h0, 32'h22222222, 32'h11111144}) begin n_mis++; $display("FAIL yumi_body_packet: got %h", packet_o); end
        pop();
    endtask

    task automatic test_reset_mid();
        send_flit(32'h123452A5);
        reset_n_i = 1'b0;
        #1;
        n_cmp++; if (v_o !== 1'b0 || link_ready_o !== 1'b0) begin n_mis++; $display("FAIL rstmid_ctrl: v=%b rdy=%b want 0 0", v_o, link_ready_o); end
        n_cmp++; if (packet_o !== 96'h0) begin n_mis++; $display("FAIL rstmid_packet: got %h want 0", packet_o); end
        #3;
        reset_n_i = 1'b1;
        tick();
        send_flit(32'h3333320A);
        send_flit(32'h44444444);
        send_flit(32'h55555555);
        n_cmp++; if (v_o !== 1'b1) begin n_mis++; $display("FAIL rstmid_after_v: got %b want 1", v_o); end
        n_cmp++; if (packet_o !== 96'h55555555_44444444_3333320A) begin n_mis++; $display("FAIL rstmid_after_packet: got %h", packet_o); end
        pop();
    endtask

    task automatic test_len_check();
`ifdef BP_CAC_FLIT_ASSEMBLER_LEN_CHECK_EN
        send_flit(32'h55555501);
        n_cmp++; if (len_err_o !== 1'b1) begin n_mis++; $display("FAIL lenchk_err: got %b want 1", len_err_o); end
        for (int i = 0; i < 5; i++) begin
            send_flit(32'hF0000000 | 32'(i));
            n_cmp++; if (v_o !== 1'b0) begin n_mis++; $display("FAIL lenchk_drop_v[%0d]: got %b want 0", i, v_o); end
        end
        n_cmp++; if (link_ready_o !== 1'b1 || packet_o !== 96'h0) begin n_mis++; $display("FAIL lenchk_after_drop: rdy=%b pkt=%h", link_ready_o, packet_o); end
        send_flit(32'h66666201);
        send_flit(32'h77777777);
        send_flit(32'h88888888);
        n_cmp++; if (v_o !== 1'b1 || packet_o !== 96'h88888888_77777777_66666201) begin n_mis++; $display("FAIL lenchk_next: v=%b pkt=%h", v_o, packet_o); end
        n_cmp++; if (len_err_o !== 1'b1) begin n_mis++; $display("FAIL lenchk_sticky: got %b want 1", len_err_o); end
        pop();
`else
        // Oversize len saturates to two body flits and is delivered normally.
        send_flit(32'h55555301);
        send_flit(32'h77777777);
        n_cmp++; if (v_o !== 1'b0) begin n_mis++; $display("FAIL sat_v_early: got %b want 0", v_o); end
        send_flit(32'h88888888);
        n_cmp++; if (v_o !== 1'b1 || packet_o !== 96'h88888888_77777777_55555301) begin n_mis++; $display("FAIL sat_packet: v=%b pkt=%h", v_o, packet_o); end
        n_cmp++; if (len_err_o !== 1'b0) begin n_mis++; $display("FAIL sat_len_err: got %b want 0", len_err_o); end
        pop();
`endif
    endtask

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        reset_n_i   = 1'b0;
        link_data_i = 32'h0;
        link_v_i    = 1'b0;
        yumi_i      = 1'b0;
        test_reset();
        test_three_flit();
        test_hold();
        test_single();
        test_gaps();
        test_yumi_ignored();
        test_reset_mid();
        test_len_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
